// File: rtl/disp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : disp_pkg
// Description : Shared constants, slot-state encoding and helpers for the
//               hex display scanner.
// Revision    : 1.0 - initial release
// ============================================================================
package disp_pkg;

  localparam int DEFAULT_REFRESH_DIV = 50000;
  localparam int DEFAULT_DEAD_CYCLES = 500;

  // Phase within one digit slot
  typedef enum logic [0:0] {
    SLOT_DEAD = 1'b0,
    SLOT_SHOW = 1'b1
  } slot_state_t;

  // Level that turns a digit driver on for the selected polarity
  function automatic logic dig_on(input int active_low);
    return (active_low != 0) ? 1'b0 : 1'b1;
  endfunction

  // Level that turns a digit driver off for the selected polarity
  function automatic logic dig_off(input int active_low);
    return (active_low != 0) ? 1'b1 : 1'b0;
  endfunction

  // Width of the digit index; never narrower than one bit
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/slot_timer.sv
`default_nettype none
// ============================================================================
// Module      : slot_timer
// Description : Per-slot cycle counter with wrap detection, DEAD/SHOW phase
//               tracking and a registered slot-start pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module slot_timer
  import disp_pkg::*;
#(
  parameter int REFRESH_DIV = DEFAULT_REFRESH_DIV,
  parameter int DEAD_CYCLES = DEFAULT_DEAD_CYCLES
) (
  input  logic clk,
  input  logic rst,
  output logic wrap,
  output logic show_nxt,
  output logic slot_start
);

  localparam int CW = $clog2(REFRESH_DIV);
  // With no dead time every slot opens directly in SHOW
  localparam slot_state_t START_STATE = (DEAD_CYCLES == 0) ? SLOT_SHOW : SLOT_DEAD;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  slot_state_t   state_q;
  slot_state_t   state_d;
  logic          slot_start_q;
  logic          slot_start_d;

  // Counter advance and wrap detection at the last cycle of a slot
  always_comb begin
    wrap         = (cnt_q == CW'(REFRESH_DIV - 1));
    cnt_d        = wrap ? '0 : cnt_q + CW'(1);
    slot_start_d = wrap;
  end

  // Next phase, evaluated against the counter value of the coming cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      SLOT_DEAD: if (cnt_d == CW'(DEAD_CYCLES)) state_d = SLOT_SHOW;
      SLOT_SHOW: if (wrap) state_d = START_STATE;
      default:   state_d = START_STATE;
    endcase
    show_nxt = (state_d == SLOT_SHOW);
  end

  // Counter, phase and pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      state_q      <= START_STATE;
      slot_start_q <= 1'b1;
    end else begin
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      slot_start_q <= slot_start_d;
    end
  end

  assign slot_start = slot_start_q;

endmodule
`default_nettype wire

// File: rtl/hex_display_scanner.sv
`default_nettype none
// ============================================================================
// Module      : hex_display_scanner
// Description : Time-multiplexed scanner for a multi-digit 7-segment display.
//               Keeps a shadow copy of the value, walks the digits, inserts
//               dead time per slot and optionally blanks leading zeros.
// Revision    : 1.0 - initial release
// ============================================================================
module hex_display_scanner
  import disp_pkg::*;
#(
  parameter  int NUM_DIGITS     = 4,
  parameter  int REFRESH_DIV    = DEFAULT_REFRESH_DIV,
  parameter  int DEAD_CYCLES    = DEFAULT_DEAD_CYCLES,
  parameter  int DIG_ACTIVE_LOW = 1,
  localparam int IW             = idx_width(NUM_DIGITS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic                    blank_lz,
  output logic [3:0]              nibble,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic [IW-1:0]           digit_idx,
  output logic                    blank,
  output logic                    slot_start
);

  localparam logic                  ON        = dig_on(DIG_ACTIVE_LOW);
  localparam logic                  OFF       = dig_off(DIG_ACTIVE_LOW);
  localparam logic [NUM_DIGITS-1:0] ALL_OFF   = {NUM_DIGITS{OFF}};
  // Without dead time the first slot after reset is already lit on digit 0
  localparam logic [NUM_DIGITS-1:0] RST_EN    =
    (DEAD_CYCLES == 0) ? {ALL_OFF[NUM_DIGITS-1:1], ON} : ALL_OFF;
  localparam logic                  RST_BLANK = (DEAD_CYCLES != 0);

  logic                    wrap;
  logic                    show_nxt;

  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [3:0]              nibble_q, nibble_d;
  logic                    lz_q, lz_d;
  logic [NUM_DIGITS-1:0]   digit_en_q, digit_en_d;
  logic                    blank_q, blank_d;

  logic [3:0]              sel_nib;
  logic                    sel_zero;
  logic                    zero_run;

  slot_timer #(
    .REFRESH_DIV (REFRESH_DIV),
    .DEAD_CYCLES (DEAD_CYCLES)
  ) u_slot_timer (
    .clk        (clk),
    .rst        (rst),
    .wrap       (wrap),
    .show_nxt   (show_nxt),
    .slot_start (slot_start)
  );

  // Shadow capture, digit advance, and per-slot nibble / blanking latch.
  // The slot data reads shadow_d so a load on the wrap edge is seen at once.
  always_comb begin
    shadow_d = load ? value : shadow_q;
    idx_d    = idx_q;
    if (wrap) idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);

    sel_nib  = 4'h0;
    sel_zero = 1'b0;
    zero_run = 1'b1;
    for (int j = NUM_DIGITS - 1; j >= 0; j--) begin
      zero_run = zero_run && (shadow_d[4*j +: 4] == 4'h0);
      if (IW'(j) == idx_d) begin
        sel_nib  = shadow_d[4*j +: 4];
        sel_zero = zero_run;
      end
    end

    nibble_d = nibble_q;
    lz_d     = lz_q;
    if (wrap) begin
      nibble_d = sel_nib;
      lz_d     = blank_lz && (idx_d != '0) && sel_zero;
    end
  end

  // Digit enables and blank follow the phase and digit of the coming cycle
  always_comb begin
    digit_en_d = ALL_OFF;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (show_nxt && !lz_d && (IW'(j) == idx_d)) digit_en_d[j] = ON;
    end
    blank_d = !show_nxt || lz_d;
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q   <= '0;
      idx_q      <= '0;
      nibble_q   <= 4'h0;
      lz_q       <= 1'b0;
      digit_en_q <= RST_EN;
      blank_q    <= RST_BLANK;
    end else begin
      shadow_q   <= shadow_d;
      idx_q      <= idx_d;
      nibble_q   <= nibble_d;
      lz_q       <= lz_d;
      digit_en_q <= digit_en_d;
      blank_q    <= blank_d;
    end
  end

  assign nibble    = nibble_q;
  assign digit_en  = digit_en_q;
  assign digit_idx = idx_q;
  assign blank     = blank_q;

endmodule
`default_nettype wire

// File: tb/tb_hex_display_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_hex_display_scanner
// Description : Directed bench for hex_display_scanner with a dead-time build
//               (DEAD_CYCLES=2) and a no-dead-time build side by side.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hex_display_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [15:0] value = 16'h0;

  logic [3:0]  nibble, nibble0;
  logic [3:0]  digit_en, digit_en0;
  logic [1:0]  digit_idx, digit_idx0;
  logic        blank, blank0;
  logic        slot_start, slot_start0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hex_display_scanner #(
    .NUM_DIGITS(4), .REFRESH_DIV(8), .DEAD_CYCLES(2), .DIG_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .value(value), .load(load), .blank_lz(blank_lz),
    .nibble(nibble), .digit_en(digit_en), .digit_idx(digit_idx),
    .blank(blank), .slot_start(slot_start)
  );

  hex_display_scanner #(
    .NUM_DIGITS(4), .REFRESH_DIV(8), .DEAD_CYCLES(0), .DIG_ACTIVE_LOW(1)
  ) dut0 (
    .clk(clk), .rst(rst), .value(value), .load(load), .blank_lz(blank_lz),
    .nibble(nibble0), .digit_en(digit_en0), .digit_idx(digit_idx0),
    .blank(blank0), .slot_start(slot_start0)
  );

  typedef struct {
    logic [15:0] value;
    logic        lz;
    logic [15:0] exp_nib;      // expected nibble per digit, digit 0 in [3:0]
    logic [3:0]  exp_blanked;  // digits that stay dark for the whole slot
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 0 of the first slot after reset
  task automatic do_reset();
    rst  = 1'b1;
    load = 1'b0;
    tick();
    rst  = 1'b0;
  endtask

  // Compares both builds at position cyc (0..31) of a scan
  task automatic check_scan_cycle(input string tag, input int cyc,
                                  input logic [15:0] nib, input logic [3:0] blanked);
    int         d;
    int         c;
    logic [3:0] lit;
    logic [3:0] exp_en;
    logic [3:0] exp_en0;
    logic       exp_blank;
    logic [3:0] exp_nib;
    d       = cyc / 8;
    c       = cyc % 8;
    lit     = ~(4'b0001 << d);
    exp_nib = nib[4*d +: 4];
    exp_blank = (c < 2) || blanked[d];
    exp_en    = exp_blank ? 4'b1111 : lit;
    exp_en0   = blanked[d] ? 4'b1111 : lit;
    check($sformatf("%s c%0d digit_en", tag, cyc), digit_en, exp_en);
    check($sformatf("%s c%0d blank", tag, cyc), blank, exp_blank);
    check($sformatf("%s c%0d nibble", tag, cyc), nibble, exp_nib);
    check($sformatf("%s c%0d digit_idx", tag, cyc), digit_idx, d);
    check($sformatf("%s c%0d slot_start", tag, cyc), slot_start, c == 0);
    check($sformatf("%s c%0d dz digit_en", tag, cyc), digit_en0, exp_en0);
    check($sformatf("%s c%0d dz blank", tag, cyc), blank0, blanked[d]);
    check($sformatf("%s c%0d dz nibble", tag, cyc), nibble0, exp_nib);
    check($sformatf("%s c%0d dz slot_start", tag, cyc), slot_start0, c == 0);
  endtask

  initial begin
    vecs[0] = '{16'hA3F5, 1'b0, 16'hA3F5, 4'b0000};
    vecs[1] = '{16'h0042, 1'b1, 16'h0042, 4'b1100};
    vecs[2] = '{16'h0000, 1'b1, 16'h0000, 4'b1110};
    vecs[3] = '{16'h0042, 1'b0, 16'h0042, 4'b0000};
    vecs[4] = '{16'h1000, 1'b1, 16'h1000, 4'b0000};
    vecs[5] = '{16'h0500, 1'b1, 16'h0500, 4'b1000};
    vecs[6] = '{16'h00F0, 1'b1, 16'h00F0, 4'b1100};

    // Reset release with an empty shadow: first full scan, reset state included
    value    = 16'h0000;
    blank_lz = 1'b0;
    do_reset();
    for (int cyc = 0; cyc < 32; cyc++) begin
      check_scan_cycle("rst_scan", cyc, 16'h0000, 4'b0000);
      tick();
    end

    // Table: load in the first slot, check the complete second scan
    for (int i = 0; i < 7; i++) begin
      do_reset();
      value    = vecs[i].value;
      blank_lz = vecs[i].lz;
      load     = 1'b1;
      for (int cyc = 0; cyc < 64; cyc++) begin
        if (cyc == 1) load = 1'b0;
        if (cyc >= 32) check_scan_cycle($sformatf("vec%0d", i), cyc - 32,
                                        vecs[i].exp_nib, vecs[i].exp_blanked);
        tick();
      end
    end

    // Load mid-slot (held until wrap) and load on the wrap edge (bypass)
    value    = 16'h1111;
    blank_lz = 1'b0;
    do_reset();
    load = 1'b1;
    for (int cyc = 0; cyc < 64; cyc++) begin
      if (cyc == 1) load = 1'b0;
      if (cyc == 44) begin value = 16'h2222; load = 1'b1; end
      if (cyc == 45) load = 1'b0;
      if (cyc == 55) begin value = 16'h3333; load = 1'b1; end
      if (cyc == 56) load = 1'b0;
      if (cyc >= 44 && cyc <= 47) check($sformatf("midload hold c%0d", cyc), nibble, 4'h1);
      if (cyc == 48) check("midload next slot nibble", nibble, 4'h2);
      if (cyc == 50) check("midload next slot digit_en", digit_en, 4'b1011);
      if (cyc == 55) check("wrapload before edge", nibble, 4'h2);
      if (cyc == 56) check("wrapload bypass nibble", nibble, 4'h3);
      if (cyc == 58) check("wrapload digit_en", digit_en, 4'b0111);
      if (cyc == 58) check("wrapload digit_idx", digit_idx, 2'd3);
      tick();
    end

    // Reset with a simultaneous load at cnt=5 of the digit-2 slot
    value = 16'h5555;
    do_reset();
    load = 1'b1;
    for (int cyc = 0; cyc < 21; cyc++) begin
      if (cyc == 1) load = 1'b0;
      tick();
    end
    check("pre-reset nibble", nibble, 4'h5);
    check("pre-reset digit_idx", digit_idx, 2'd2);
    rst   = 1'b1;
    load  = 1'b1;
    value = 16'hFFFF;
    tick();
    rst  = 1'b0;
    load = 1'b0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      check_scan_cycle("rst_load", cyc, 16'h0000, 4'b0000);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
